// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lif_pkg
// Description : Shared constants, FSM state type and index-width helper for
//               the time-multiplexed LIF neuron array scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package lif_pkg;

    // Default datapath configuration
    localparam int unsigned c_N_NEURONS  = 4;
    localparam int unsigned c_WIDTH      = 5;
    localparam int unsigned c_THRESHOLD  = 10;
    localparam int unsigned c_LEAK_SHIFT = 1;

    // Scheduler states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Width of a neuron index; never less than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lif_array_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : lif_array_sched_if
// Description : Handshake bundle between the stimulus front-end, the LIF
//               scheduler and the spike consumer.
//               master : drives in_valid/in_current, out_ready, rd_idx
//               slave  : drives in_ready, out_valid/out_spikes, rd_pot
// Revision    : 1.0 - initial release
// ============================================================================
interface lif_array_sched_if #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 5,
    parameter int IDXW      = lif_pkg::idx_width(N_NEURONS)
);
    logic                       in_valid;
    logic                       in_ready;
    logic [N_NEURONS*WIDTH-1:0] in_current;
    logic                       out_valid;
    logic                       out_ready;
    logic [N_NEURONS-1:0]       out_spikes;
    logic [IDXW-1:0]            rd_idx;
    logic [WIDTH-1:0]           rd_pot;

    modport master (
        output in_valid, in_current, out_ready, rd_idx,
        input  in_ready, out_valid, out_spikes, rd_pot
    );

    modport slave (
        input  in_valid, in_current, out_ready, rd_idx,
        output in_ready, out_valid, out_spikes, rd_pot
    );
endinterface
`default_nettype wire

// File: rtl/lif_core.sv
`default_nettype none
// ============================================================================
// Module      : lif_core
// Description : Combinational leak/integrate/fire step for one neuron.
//               Sum is formed one bit wider than the operands so a large
//               current never wraps back below threshold.
// Ports       : i_cur    - input current
//               i_pot    - present membrane potential
//               o_ns_pot - next potential (0 when the neuron fires)
//               o_fire   - neuron fires this timestep
// Revision    : 1.0 - initial release
// ============================================================================
module lif_core #(
    parameter int WIDTH      = 5,
    parameter int THRESHOLD  = 10,
    parameter int LEAK_SHIFT = 1
) (
    input  wire logic [WIDTH-1:0] i_cur,
    input  wire logic [WIDTH-1:0] i_pot,
    output logic      [WIDTH-1:0] o_ns_pot,
    output logic                  o_fire
);
    logic [WIDTH:0] w_ns;

    assign w_ns     = {1'b0, i_cur} + ({1'b0, i_pot} >> LEAK_SHIFT);
    assign o_fire   = (w_ns >= (WIDTH+1)'(THRESHOLD));
    // Below threshold the sum fits in WIDTH bits, so dropping the MSB is exact
    assign o_ns_pot = o_fire ? '0 : w_ns[WIDTH-1:0];
endmodule
`default_nettype wire

// File: rtl/lif_array_sched.sv
`default_nettype none
// ============================================================================
// Module      : lif_array_sched
// Description : Time-multiplexed scheduler for N leaky integrate-and-fire
//               neurons sharing one lif_core. A current vector is captured
//               in IDLE, neurons are updated one per cycle in UPDATE, and the
//               resulting spike vector is presented in HOLD until taken.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-low reset
//               bus   - slave side of lif_array_sched_if (input vector
//                       handshake, spike vector handshake, potential readback)
// Revision    : 1.0 - initial release
// ============================================================================
module lif_array_sched
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = c_N_NEURONS,
    parameter int WIDTH      = c_WIDTH,
    parameter int THRESHOLD  = c_THRESHOLD,
    parameter int LEAK_SHIFT = c_LEAK_SHIFT
) (
    input  wire logic         clk,
    input  wire logic         reset,
    lif_array_sched_if.slave  bus
);
    localparam int IDXW = idx_width(N_NEURONS);
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(N_NEURONS - 1);

    state_t               r_state;
    logic [IDXW-1:0]      r_idx;
    logic [WIDTH-1:0]     r_pot [N_NEURONS];
    logic [WIDTH-1:0]     r_cur [N_NEURONS];
    logic [N_NEURONS-1:0] r_spk_acc;
    logic [N_NEURONS-1:0] r_spikes;
    logic                 r_out_valid;

    logic [WIDTH-1:0]     w_cur;
    logic [WIDTH-1:0]     w_pot;
    logic [WIDTH-1:0]     w_ns_pot;
    logic                 w_fire;
    logic [N_NEURONS-1:0] w_spk_next;

    // Shared datapath: operates on whichever neuron r_idx points at
    assign w_cur = r_cur[r_idx];
    assign w_pot = r_pot[r_idx];

    lif_core #(
        .WIDTH      (WIDTH),
        .THRESHOLD  (THRESHOLD),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_core (
        .i_cur    (w_cur),
        .i_pot    (w_pot),
        .o_ns_pot (w_ns_pot),
        .o_fire   (w_fire)
    );

    // Accumulator with the current neuron's result merged in, so the last
    // neuron's spike lands in the presented vector on the same edge
    always_comb begin
        w_spk_next        = r_spk_acc;
        w_spk_next[r_idx] = w_fire;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_spk_acc   <= '0;
            r_spikes    <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_pot[i] <= '0;
                r_cur[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < N_NEURONS; i++) begin
                            r_cur[i] <= bus.in_current[i*WIDTH +: WIDTH];
                        end
                        r_spk_acc <= '0;
                        r_idx     <= '0;
                        r_state   <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_pot[r_idx] <= w_ns_pot;
                    r_spk_acc    <= w_spk_next;
                    if (r_idx == c_LAST_IDX) begin
                        r_idx       <= '0;
                        r_spikes    <= w_spk_next;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_spikes = r_spikes;

    // Debug readback; indices past the last neuron read as zero
    generate
        if ((1 << IDXW) == N_NEURONS) begin : g_rd_full
            assign bus.rd_pot = r_pot[bus.rd_idx];
        end else begin : g_rd_guard
            assign bus.rd_pot = (bus.rd_idx <= c_LAST_IDX) ? r_pot[bus.rd_idx] : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lif_array_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_array_sched
// Description : Self-checking bench for lif_array_sched. A timestep-level
//               model computes each whole timestep arithmetically at accept
//               time and is compared against the DUT every cycle; directed
//               scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_array_sched;
    localparam int N  = 4;
    localparam int W  = 5;
    localparam int TH = 10;
    localparam int LS = 1;

    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    lif_array_sched_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

    lif_array_sched #(
        .N_NEURONS  (N),
        .WIDTH      (W),
        .THRESHOLD  (TH),
        .LEAK_SHIFT (LS)
    ) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timestep-level reference model ----------------
    int             m_pot [N];   // potentials committed after last full timestep
    int             m_new [N];   // potentials the in-flight timestep will produce
    logic [N-1:0]   m_pend;
    logic [N-1:0]   m_spk  = '0;
    bit             m_ready = 1'b1;
    bit             m_valid = 1'b0;
    int             m_cnt   = 0;  // cycles left until the spike vector appears

    initial begin
        for (int i = 0; i < N; i++) begin
            m_pot[i] = 0;
            m_new[i] = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_pot[i] = 0;
                m_new[i] = 0;
            end
            m_spk   = '0;
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else if (m_ready) begin
            if (bus.in_valid) begin
                for (int i = 0; i < N; i++) begin
                    int cur, ns;
                    cur = int'(bus.in_current[i*W +: W]);
                    ns  = cur + m_pot[i] / (1 << LS);
                    m_pend[i] = (ns >= TH);
                    m_new[i]  = (ns >= TH) ? 0 : ns;
                end
                m_ready = 1'b0;
                m_cnt   = N;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_pot   = m_new;
                m_spk   = m_pend;
                m_valid = 1'b1;
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready",   bus.in_ready,   1);
            check("rst_out_valid",  bus.out_valid,  0);
            check("rst_out_spikes", bus.out_spikes, 0);
            check("rst_rd_pot",     bus.rd_pot,     0);
        end else begin
            int ri, exp_pot;
            ri = int'(bus.rd_idx);
            // neurons below the number already processed show their new value
            exp_pot = (m_cnt > 0 && ri < N - m_cnt) ? m_new[ri] : m_pot[ri];
            check("in_ready",   bus.in_ready,   m_ready);
            check("out_valid",  bus.out_valid,  m_valid);
            check("out_spikes", bus.out_spikes, m_spk);
            check("rd_pot",     bus.rd_pot,     exp_pot);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [N*W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        logic [N*W-1:0] v;
        v[0*W +: W] = W'(c0);
        v[1*W +: W] = W'(c1);
        v[2*W +: W] = W'(c2);
        v[3*W +: W] = W'(c3);
        return v;
    endfunction

    // Offer a vector, wait for acceptance, then wait for the spike vector.
    // Returns at the negedge of the first out_valid cycle.
    task automatic run_step(input logic [N*W-1:0] cur, output logic [N-1:0] spk, output int lat);
        int guard;
        @(posedge clk) #1;
        bus.in_current = cur;
        bus.in_valid   = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.in_ready && guard < 50);
        if (!bus.in_ready) check("accept_timeout", 0, 1);
        @(posedge clk) #1;
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) check("out_valid_timeout", 0, 1);
        spk = bus.out_spikes;
    endtask

    task automatic peek_pot(input int idx, input int exp, input string name);
        @(posedge clk) #1;
        bus.rd_idx = 2'(idx);
        @(negedge clk);
        check(name, bus.rd_pot, exp);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [N-1:0] spk;
        logic [N-1:0] held;
        int           lat;
        int           acc_t [$];
        int           outs;
        int           cyc;
        int           exp_pot2 [3];

        exp_pot2[0] = 4;
        exp_pot2[1] = 6;
        exp_pot2[2] = 7;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_current = '0;
        bus.out_ready  = 1'b1;
        bus.rd_idx     = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("init_in_ready",  bus.in_ready,  1);
        check("init_out_valid", bus.out_valid, 0);
        for (int i = 0; i < N; i++) peek_pot(i, 0, "init_pot");

        // Integrate without firing: 4, 6, 7
        for (int s = 0; s < 3; s++) begin
            run_step(pack4(4, 4, 4, 4), spk, lat);
            check("integ_latency", lat, N + 1);
            check("integ_spikes", spk, 0);
            peek_pot(0, exp_pot2[s], "integ_pot0");
        end

        // Neuron 2 fires and clears; others hold at 7 (4 + 7>>1)
        run_step(pack4(4, 4, 12, 4), spk, lat);
        check("fire_spikes", spk, 4'b0100);
        peek_pot(2, 0, "fire_pot2");
        peek_pot(0, 7, "fire_pot0");
        peek_pot(3, 7, "fire_pot3");

        // No wrap: bring neuron 0 to 9, then 31 + 4 = 35 must fire
        run_step(pack4(6, 0, 0, 0), spk, lat);
        check("nowrap_pre_spikes", spk, 0);
        peek_pot(0, 9, "nowrap_pot0_pre");
        run_step(pack4(31, 0, 0, 0), spk, lat);
        check("nowrap_spikes", spk, 4'b0001);
        peek_pot(0, 0, "nowrap_pot0");

        // Back-pressure: hold spike vector for 10 cycles, ignore extra in_valid
        bus.out_ready = 1'b0;
        run_step(pack4(3, 11, 2, 9), spk, lat);
        check("bp_latency", lat, N + 1);
        held = spk;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk) #1;
            bus.in_valid   = c[0];
            bus.in_current = pack4(31, 31, 31, 31);
            @(negedge clk);
            check("bp_out_valid",  bus.out_valid,  1);
            check("bp_in_ready",   bus.in_ready,   0);
            check("bp_out_spikes", bus.out_spikes, held);
        end
        @(posedge clk) #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_last_hold", bus.out_valid, 1);
        @(negedge clk);
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_ready", bus.in_ready,  1);

        // Back-to-back: accept spacing must be N+2, no timestep lost
        @(posedge clk) #1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        outs = 0;
        for (cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc_t.push_back(cyc);
            if (bus.out_valid && bus.out_ready) outs++;
            @(posedge clk) #1;
            bus.in_current = ($urandom & 32'hFFFFF);
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts_enough", acc_t.size() >= 6, 1);
        for (int k = 1; k < acc_t.size(); k++) check("b2b_spacing", acc_t[k] - acc_t[k-1], N + 2);
        check("b2b_no_loss", (acc_t.size() - outs) inside {0, 1}, 1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            @(posedge clk) #1;
            bus.in_valid   = ($urandom_range(0, 1) == 1);
            bus.out_ready  = ($urandom_range(0, 9) < 7);
            bus.in_current = ($urandom & 32'hFFFFF);
            bus.rd_idx     = 2'($urandom_range(0, N - 1));
        end

        // Reset in the middle of an update aborts the timestep
        bus.out_ready = 1'b1;
        @(posedge clk) #1;
        bus.in_valid   = 1'b1;
        bus.in_current = pack4(31, 31, 31, 31);
        begin
            int guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!bus.in_ready && guard < 50);
        end
        @(posedge clk) #1;
        bus.in_valid = 1'b0;
        @(posedge clk) #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid",  bus.out_valid,  0);
        check("midrst_out_spikes", bus.out_spikes, 0);
        check("midrst_in_ready",   bus.in_ready,   1);
        @(posedge clk) #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) peek_pot(i, 0, "midrst_pot");

        // Fresh timestep after reset behaves normally
        run_step(pack4(12, 0, 0, 0), spk, lat);
        check("post_rst_latency", lat, N + 1);
        check("post_rst_spikes",  spk, 4'b0001);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
